fetch_unit: RTL and testbench

Instruction fetch stage that produces the `stage1_instruction_bits` / `stage1_pc` pair consumed by the Decode stage. It issues aligned 64-bit reads on the memory bus, splits each returned line into two 32-bit instructions, and presents them to Decode one at a time under a valid/ready handshake. It also accepts PC redirects from later stages and discards in-flight stale responses.

---
 rtl/fetch_unit.sv | 184 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding Decode.
//
// Issues one aligned 64-bit line read at a time, splits the returned line into
// two 32-bit instructions and hands them to Decode one per accepted handshake.
// Redirects from later stages retarget fetch and any stale in-flight response
// is absorbed without being presented.
//
// Ports:
//   clk                      clock, all state changes on the rising edge
//   reset                    synchronous, active-low
//   bus_req / bus_addr       read request and aligned line address (registered)
//   bus_resp_valid/_data     response strobe and returned line
//   redirect_valid/_pc       new fetch PC from a taken branch or jump
//   stage1_valid             instruction/PC pair below is meaningful (registered)
//   stage1_instruction_bits  instruction presented to Decode (registered)
//   stage1_pc                address of stage1_instruction_bits (registered)
//   decode_ready             Decode accepts the presented instruction this cycle
module fetch_unit #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter logic [63:0] RESET_PC       = 64'h0
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        bus_req,
  output logic [63:0]                 bus_addr,
  input  logic                        bus_resp_valid,
  input  logic [BUS_DATA_WIDTH-1:0]   bus_resp_data,
  input  logic                        redirect_valid,
  input  logic [63:0]                 redirect_pc,
  output logic                        stage1_valid,
  output logic [BUS_DATA_WIDTH/2-1:0] stage1_instruction_bits,
  output logic [63:0]                 stage1_pc,
  input  logic                        decode_ready
);

  localparam int unsigned INST_W    = BUS_DATA_WIDTH / 2;
  localparam logic [63:0] LINE_MASK = ~64'h7;
  localparam logic [63:0] INST_MASK = ~64'h3;
  localparam logic [63:0] INST_STEP = 64'd4;
  localparam logic [63:0] LINE_STEP = 64'd8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DRAIN   = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t                    state;
  state_t                    nxt_state;
  logic [63:0]               fetch_pc;
  logic [63:0]               nxt_fetch_pc;
  logic [63:0]               line_base;
  logic [63:0]               nxt_line_base;
  logic [BUS_DATA_WIDTH-1:0] line;
  logic [BUS_DATA_WIDTH-1:0] nxt_line;
  logic                      slot0_v;
  logic                      nxt_slot0_v;
  logic                      slot1_v;
  logic                      nxt_slot1_v;

  logic                      transfer;
  logic                      nxt_stage1_valid;
  logic [INST_W-1:0]         nxt_inst;
  logic [63:0]               nxt_pc;

  // A transfer is only possible while an instruction is actually presented.
  assign transfer = stage1_valid & decode_ready;

  // Next-state and next-register computation; redirect dominates outside IDLE.
  always_comb begin
    nxt_state     = state;
    nxt_fetch_pc  = fetch_pc;
    nxt_line_base = line_base;
    nxt_line      = line;
    nxt_slot0_v   = slot0_v;
    nxt_slot1_v   = slot1_v;

    unique case (state)
      IDLE: begin
        nxt_state = FETCH;
      end

      FETCH: begin
        if (redirect_valid) begin
          nxt_fetch_pc = redirect_pc & INST_MASK;
          nxt_slot0_v  = 1'b0;
          nxt_slot1_v  = 1'b0;
          // A response arriving now is dropped; otherwise it is still owed.
          nxt_state    = bus_resp_valid ? FETCH : DISCARD;
        end else if (bus_resp_valid) begin
          nxt_line      = bus_resp_data;
          nxt_line_base = bus_addr;
          nxt_slot0_v   = ~fetch_pc[2];
          nxt_slot1_v   = 1'b1;
          nxt_state     = DRAIN;
        end
      end

      DRAIN: begin
        if (redirect_valid) begin
          // A same-cycle transfer still counts; nothing else from this line.
          nxt_fetch_pc = redirect_pc & INST_MASK;
          nxt_slot0_v  = 1'b0;
          nxt_slot1_v  = 1'b0;
          nxt_state    = FETCH;
        end else if (transfer) begin
          if (slot0_v) begin
            nxt_slot0_v = 1'b0;
          end else begin
            nxt_slot1_v = 1'b0;
          end
          // Last valid slot consumed: move on to the next sequential line.
          if (!(slot0_v && slot1_v)) begin
            nxt_fetch_pc = line_base + LINE_STEP;
            nxt_state    = FETCH;
          end
        end
      end

      DISCARD: begin
        if (redirect_valid) begin
          nxt_fetch_pc = redirect_pc & INST_MASK;
          nxt_slot0_v  = 1'b0;
          nxt_slot1_v  = 1'b0;
        end
        // The owed response retires the outstanding request, even alongside
        // a redirect, so fetch can never wait on a response already consumed.
        if (bus_resp_valid) begin
          nxt_state = FETCH;
        end
      end

      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // Values the registered Decode-side outputs take after this edge.
  always_comb begin
    nxt_stage1_valid = (nxt_state == DRAIN) && (nxt_slot0_v || nxt_slot1_v);
    if (nxt_slot0_v) begin
      nxt_inst = nxt_line[INST_W-1:0];
      nxt_pc   = nxt_line_base;
    end else begin
      nxt_inst = nxt_line[BUS_DATA_WIDTH-1:INST_W];
      nxt_pc   = nxt_line_base + INST_STEP;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                   <= IDLE;
      fetch_pc                <= RESET_PC;
      line_base               <= 64'h0;
      line                    <= '0;
      slot0_v                 <= 1'b0;
      slot1_v                 <= 1'b0;
      bus_req                 <= 1'b0;
      bus_addr                <= RESET_PC & LINE_MASK;
      stage1_valid            <= 1'b0;
      stage1_instruction_bits <= '0;
      stage1_pc               <= 64'h0;
    end else begin
      state        <= nxt_state;
      fetch_pc     <= nxt_fetch_pc;
      line_base    <= nxt_line_base;
      line         <= nxt_line;
      slot0_v      <= nxt_slot0_v;
      slot1_v      <= nxt_slot1_v;
      bus_req      <= (nxt_state == FETCH);
      bus_addr     <= nxt_fetch_pc & LINE_MASK;
      stage1_valid <= nxt_stage1_valid;
      // Instruction/PC hold their last values while nothing is presented.
      if (nxt_stage1_valid) begin
        stage1_instruction_bits <= nxt_inst;
        stage1_pc               <= nxt_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        bus_req;
  logic [63:0] bus_addr;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stage1_valid;
  logic [31:0] stage1_instruction_bits;
  logic [63:0] stage1_pc;
  logic        decode_ready;

  int checks = 0;
  int errors = 0;

  // Expected deliveries: {instruction, pc}.
  logic [95:0] exp_q[$];

  fetch_unit #(
    .BUS_DATA_WIDTH(64),
    .RESET_PC      (64'h1000)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .bus_req                (bus_req),
    .bus_addr               (bus_addr),
    .bus_resp_valid         (bus_resp_valid),
    .bus_resp_data          (bus_resp_data),
    .redirect_valid         (redirect_valid),
    .redirect_pc            (redirect_pc),
    .stage1_valid           (stage1_valid),
    .stage1_instruction_bits(stage1_instruction_bits),
    .stage1_pc              (stage1_pc),
    .decode_ready           (decode_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable to sample.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (reset && stage1_valid && decode_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        assert (1'b0) else begin
          errors++;
          $error("FAIL unexpected_delivery observed pc %h inst %h expected none", stage1_pc, stage1_instruction_bits);
        end
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        chk("deliver_inst", 64'(stage1_instruction_bits), 64'(e[95:64]));
        chk("deliver_pc", stage1_pc, e[63:0]);
      end
    end
  end

  initial begin
    reset          = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_data  = 64'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    decode_ready   = 1'b0;
    step();
    step();

    // Reset values
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_addr", bus_addr, 64'h1000);
    chk("rst_valid", 64'(stage1_valid), 64'd0);
    chk("rst_inst", 64'(stage1_instruction_bits), 64'd0);
    chk("rst_pc", stage1_pc, 64'd0);

    // Release reset: request follows the first edge with reset high
    reset = 1'b1;
    step();
    chk("first_req", 64'(bus_req), 64'd1);
    chk("first_addr", bus_addr, 64'h1000);

    // Aligned line with a 5-cycle Decode stall
    bus_resp_valid = 1'b1;
    bus_resp_data  = 64'h00500093_00100093;
    exp_q.push_back({32'h00100093, 64'h1000});
    exp_q.push_back({32'h00500093, 64'h1004});
    step();
    bus_resp_valid = 1'b0;
    chk("resp_req_drop", 64'(bus_req), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(stage1_valid), 64'd1);
      chk("stall_inst", 64'(stage1_instruction_bits), 64'h00100093);
      chk("stall_pc", stage1_pc, 64'h1000);
      step();
    end
    decode_ready = 1'b1;
    step();
    chk("slot1_valid", 64'(stage1_valid), 64'd1);
    chk("slot1_pc", stage1_pc, 64'h1004);
    step();
    chk("next_req", 64'(bus_req), 64'd1);
    chk("next_addr", bus_addr, 64'h1008);
    chk("next_valid", 64'(stage1_valid), 64'd0);

    // Back-to-back delivery with ready held high
    bus_resp_valid = 1'b1;
    bus_resp_data  = 64'h11111111_22222222;
    exp_q.push_back({32'h22222222, 64'h1008});
    exp_q.push_back({32'h11111111, 64'h100C});
    step();
    bus_resp_valid = 1'b0;
    chk("b2b0_pc", stage1_pc, 64'h1008);
    step();
    chk("b2b1_pc", stage1_pc, 64'h100C);
    chk("b2b1_valid", 64'(stage1_valid), 64'd1);
    step();
    chk("b2b_next_addr", bus_addr, 64'h1010);

    // Misaligned redirect (low bits ignored) during DRAIN
    decode_ready   = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_data  = 64'h33333333_44444444;
    step();
    bus_resp_valid = 1'b0;
    chk("drain_pc", stage1_pc, 64'h1010);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2006;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid", 64'(stage1_valid), 64'd0);
    chk("redir_req", 64'(bus_req), 64'd1);
    chk("redir_addr", bus_addr, 64'h2000);
    decode_ready   = 1'b1;
    bus_resp_valid = 1'b1;
    bus_resp_data  = 64'hAAAAAAAA_BBBBBBBB;
    exp_q.push_back({32'hAAAAAAAA, 64'h2004});
    step();
    bus_resp_valid = 1'b0;
    chk("hi_only_inst", 64'(stage1_instruction_bits), 64'hAAAAAAAA);
    chk("hi_only_pc", stage1_pc, 64'h2004);
    step();
    chk("hi_only_next_valid", 64'(stage1_valid), 64'd0);
    chk("hi_only_next_addr", bus_addr, 64'h2008);

    // Redirect with request outstanding: stale response absorbed
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    step();
    redirect_valid = 1'b0;
    chk("discard_req", 64'(bus_req), 64'd0);
    step();
    chk("discard_req_hold", 64'(bus_req), 64'd0);
    step();
    bus_resp_valid = 1'b1;
    bus_resp_data  = 64'hDEADBEEF_DEADBEEF;
    step();
    bus_resp_valid = 1'b0;
    chk("post_discard_valid", 64'(stage1_valid), 64'd0);
    chk("post_discard_req", 64'(bus_req), 64'd1);
    chk("post_discard_addr", bus_addr, 64'h3000);

    // Redirect together with a response: data dropped
    redirect_valid = 1'b1;
    redirect_pc    = 64'h4000;
    bus_resp_valid = 1'b1;
    bus_resp_data  = 64'hCAFECAFE_CAFECAFE;
    step();
    redirect_valid = 1'b0;
    bus_resp_valid = 1'b0;
    chk("simul_valid", 64'(stage1_valid), 64'd0);
    chk("simul_req", 64'(bus_req), 64'd1);
    chk("simul_addr", bus_addr, 64'h4000);

    // Reset mid-DRAIN
    decode_ready   = 1'b0;
    bus_resp_valid = 1'b1;
    bus_resp_data  = 64'h55555555_66666666;
    step();
    bus_resp_valid = 1'b0;
    chk("pre_rst_valid", 64'(stage1_valid), 64'd1);
    chk("pre_rst_pc", stage1_pc, 64'h4000);
    reset = 1'b0;
    step();
    chk("mid_rst_valid", 64'(stage1_valid), 64'd0);
    chk("mid_rst_req", 64'(bus_req), 64'd0);
    chk("mid_rst_addr", bus_addr, 64'h1000);
    reset = 1'b1;
    step();
    chk("restart_req", 64'(bus_req), 64'd1);
    chk("restart_addr", bus_addr, 64'h1000);

    // Wrap of the line address at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
    bus_resp_valid = 1'b1;
    bus_resp_data  = 64'h0;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr", bus_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    decode_ready   = 1'b1;
    bus_resp_data  = 64'h77777777_88888888;
    exp_q.push_back({32'h88888888, 64'hFFFF_FFFF_FFFF_FFF8});
    exp_q.push_back({32'h77777777, 64'hFFFF_FFFF_FFFF_FFFC});
    step();
    bus_resp_valid = 1'b0;
    step();
    step();
    chk("wrap_next_req", 64'(bus_req), 64'd1);
    chk("wrap_next_addr", bus_addr, 64'h0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
